// File: rtl/bit_router.sv
// Registered bit router: each output bit takes a programmable input bit or a constant.
// Optional per-bit output inversion when BIT_ROUTER_INV_EN is defined.
module bit_router #(
  parameter int N_IN  = 20,
  parameter int N_OUT = 40,
  localparam int SEL_W = $clog2(N_IN + 2),
  localparam int AW    = (N_OUT > 1) ? $clog2(N_OUT) : 1,
`ifdef BIT_ROUTER_INV_EN
  localparam int RD_W  = SEL_W + 1
`else
  localparam int RD_W  = SEL_W
`endif
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [N_IN-1:0]  in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [N_OUT-1:0] out_data,
  input  logic             cfg_we,
  input  logic [AW-1:0]    cfg_addr,
  input  logic [SEL_W-1:0] cfg_sel,
`ifdef BIT_ROUTER_INV_EN
  input  logic             cfg_inv,
`endif
  output logic [RD_W-1:0]  cfg_rdata,
  output logic             cfg_err
);

  logic [SEL_W-1:0] table_q [N_OUT];
  logic [SEL_W-1:0] table_d [N_OUT];
  logic [N_OUT-1:0] mask_q, mask_d;
  logic             out_valid_q, out_valid_d;
  logic [N_OUT-1:0] out_data_q, out_data_d;
  logic             cfg_err_q, cfg_err_d;
  logic             accept, wr_ok;
  logic [N_OUT-1:0] routed;

  // Codes above N_IN-1 select a constant, so unused in_data bits never leak through.
  function automatic logic route(input logic [SEL_W-1:0] sel, input logic [N_IN-1:0] d);
    logic r;
    r = (sel == SEL_W'(N_IN + 1));
    for (int i = 0; i < N_IN; i++)
      if (sel == SEL_W'(i)) r = d[i];
    return r;
  endfunction

  assign in_ready  = !out_valid_q || out_ready;
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign cfg_err   = cfg_err_q;

  always_comb begin
    accept = in_valid && in_ready;
    wr_ok  = cfg_we && (int'(cfg_addr) < N_OUT) && (int'(cfg_sel) <= N_IN + 1);
    for (int k = 0; k < N_OUT; k++)
      routed[k] = route(table_q[k], in_data) ^ mask_q[k];
    out_valid_d = accept ? 1'b1 : (out_ready ? 1'b0 : out_valid_q);
    out_data_d  = accept ? routed : out_data_q;
    cfg_err_d   = cfg_we && !wr_ok;
  end

  always_comb begin
    mask_d = mask_q;
    for (int k = 0; k < N_OUT; k++) begin
      table_d[k] = table_q[k];
      if (wr_ok && cfg_addr == AW'(k)) begin
        table_d[k] = cfg_sel;
`ifdef BIT_ROUTER_INV_EN
        mask_d[k]  = cfg_inv;
`endif
      end
    end
  end

  always_comb begin
    cfg_rdata = '0;
    for (int k = 0; k < N_OUT; k++)
      if (cfg_addr == AW'(k)) begin
`ifdef BIT_ROUTER_INV_EN
        cfg_rdata = {mask_q[k], table_q[k]};
`else
        cfg_rdata = table_q[k];
`endif
      end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      cfg_err_q   <= 1'b0;
      mask_q      <= '0;
      for (int k = 0; k < N_OUT; k++)
        table_q[k] <= SEL_W'(k % N_IN);
    end else begin
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      cfg_err_q   <= cfg_err_d;
      mask_q      <= mask_d;
      for (int k = 0; k < N_OUT; k++)
        table_q[k] <= table_d[k];
    end
  end

endmodule
